// File: rtl/regfile_write_queue_if.sv
// ---------------------------------------------------------------------------
// regfile_write_queue_if
//   Writeback request channel from the pipeline into the register-file write
//   queue. A request transfers on a rising clock edge where InValid and
//   InReady are both high.
//
//   InValid    : request valid (pipeline -> queue)
//   InReady    : queue can accept a request (queue -> pipeline)
//   InRegister : destination register of the request
//   InData     : data to write
//
//   master : pipeline side (drives the request)
//   slave  : queue side (drives InReady)
// ---------------------------------------------------------------------------
interface regfile_write_queue_if #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 5
);

  logic              InValid;
  logic              InReady;
  logic [AWIDTH-1:0] InRegister;
  logic [WIDTH-1:0]  InData;

  modport master (
    output InValid,
    output InRegister,
    output InData,
    input  InReady
  );

  modport slave (
    input  InValid,
    input  InRegister,
    input  InData,
    output InReady
  );

endinterface

// File: rtl/regfile_write_queue.sv
// ---------------------------------------------------------------------------
// regfile_write_queue
//   Initiator side of the register file's write port. Writeback requests are
//   buffered in an in-order FIFO and retired one per clock onto the register
//   file's synchronous write port. While a write is still queued, the bypass
//   outputs supply its data to the asynchronous read ports so they never see
//   a stale value.
//
//   Clk            : clock, rising edge
//   Reset_n        : asynchronous active-low reset
//   inPort         : writeback request channel (slave side)
//   WriteHold      : inhibits retirement while the write port is borrowed
//   WriteData      : register file WriteData (head entry, 0 when empty)
//   WriteRegister  : register file WriteRegister (head entry, 0 when empty)
//   RegWrite       : register file write enable
//   ReadRegister1/2: read addresses snooped for bypass
//   Bypass1/2Valid : a pending write targets the snooped register
//   Bypass1/2Data  : data of the newest such pending write, else 0
//   Count          : number of occupied entries
// ---------------------------------------------------------------------------
module regfile_write_queue #(
  parameter int DEPTH  = 4,   // power of two, >= 2
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 5
) (
  input  logic                     Clk,
  input  logic                     Reset_n,

  regfile_write_queue_if.slave     inPort,

  input  logic                     WriteHold,
  output logic [WIDTH-1:0]         WriteData,
  output logic [AWIDTH-1:0]        WriteRegister,
  output logic                     RegWrite,

  input  logic [AWIDTH-1:0]        ReadRegister1,
  input  logic [AWIDTH-1:0]        ReadRegister2,
  output logic                     Bypass1Valid,
  output logic [WIDTH-1:0]         Bypass1Data,
  output logic                     Bypass2Valid,
  output logic [WIDTH-1:0]         Bypass2Data,

  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Entry storage, split into address and data arrays.
  logic [AWIDTH-1:0] regMem  [DEPTH];
  logic [WIDTH-1:0]  dataMem [DEPTH];

  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;

  logic notEmpty;
  logic accept;
  logic store;
  logic pop;

  // -------------------------------------------------------------------------
  // Handshake and retirement control
  // -------------------------------------------------------------------------
  // InReady looks only at the registered Count, so a full queue refuses a
  // request even on a cycle where the head retires.
  assign inPort.InReady = (Count < FULL_COUNT);
  assign notEmpty       = (Count != '0);

  assign accept = inPort.InValid & inPort.InReady;
  // Writes to register 0 complete the handshake but are discarded.
  assign store  = accept & (inPort.InRegister != '0);

  assign RegWrite      = notEmpty & ~WriteHold;
  assign pop           = RegWrite;
  assign WriteRegister = notEmpty ? regMem[rdPtr]  : '0;
  assign WriteData     = notEmpty ? dataMem[rdPtr] : '0;

  // -------------------------------------------------------------------------
  // Pointers and occupancy
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      Count <= '0;
    end else begin
      if (store) wrPtr <= wrPtr + 1'b1;
      if (pop)   rdPtr <= rdPtr + 1'b1;
      case ({store, pop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
    end
  end

  // NOTE: the entry arrays are deliberately not reset; Count = 0 marks every
  // slot unoccupied, so stale contents are never driven or bypassed.
  always_ff @(posedge Clk) begin
    if (store) begin
      regMem[wrPtr]  <= inPort.InRegister;
      dataMem[wrPtr] <= inPort.InData;
    end
  end

  // -------------------------------------------------------------------------
  // Read bypass
  //   Walk occupied slots from oldest (head) to newest; a later match
  //   overrides an earlier one, leaving the newest pending data. The head is
  //   included even when it retires this cycle, because the register file
  //   only stores it at the coming edge.
  // -------------------------------------------------------------------------
  logic [PW-1:0] slot;

  // NOTE: every output of this block gets a default first so no path through
  // the loop leaves a variable unassigned (which would infer a latch).
  always_comb begin
    Bypass1Valid = 1'b0;
    Bypass1Data  = '0;
    Bypass2Valid = 1'b0;
    Bypass2Data  = '0;
    slot         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rdPtr + PW'(i);
      if (CW'(i) < Count) begin
        if ((ReadRegister1 != '0) && (regMem[slot] == ReadRegister1)) begin
          Bypass1Valid = 1'b1;
          Bypass1Data  = dataMem[slot];
        end
        if ((ReadRegister2 != '0) && (regMem[slot] == ReadRegister2)) begin
          Bypass2Valid = 1'b1;
          Bypass2Data  = dataMem[slot];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_queue
//   Directed bench for regfile_write_queue. Accepted requests push their
//   expected register-file write into a queue; a monitor compares every
//   retirement (RegWrite high at the falling edge) against the queue head.
//   Occupancy, handshake and bypass values are checked directly.
// ---------------------------------------------------------------------------
module tb_regfile_write_queue;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic        Clk;
  logic        Reset_n;
  logic        WriteHold;
  logic [31:0] WriteData;
  logic [4:0]  WriteRegister;
  logic        RegWrite;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic        Bypass1Valid;
  logic [31:0] Bypass1Data;
  logic        Bypass2Valid;
  logic [31:0] Bypass2Data;
  logic [2:0]  Count;

  int  total = 0;
  int  bad   = 0;
  wr_t expQ[$];

  regfile_write_queue_if #(.WIDTH(32), .AWIDTH(5)) inIf ();

  regfile_write_queue #(.DEPTH(4), .WIDTH(32), .AWIDTH(5)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .inPort        (inIf.slave),
    .WriteHold     (WriteHold),
    .WriteData     (WriteData),
    .WriteRegister (WriteRegister),
    .RegWrite      (RegWrite),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .Bypass1Valid  (Bypass1Valid),
    .Bypass1Data   (Bypass1Data),
    .Bypass2Valid  (Bypass2Valid),
    .Bypass2Data   (Bypass2Data),
    .Count         (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each retirement must match the oldest outstanding expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge Clk);
      if (Reset_n === 1'b1 && RegWrite === 1'b1) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got r%0d=%h expected none (t=%0t)",
                   WriteRegister, WriteData, $time);
        end else begin
          e = expQ.pop_front();
          check("wr_reg", 32'(WriteRegister), 32'(e.r));
          check("wr_data", WriteData, e.d);
        end
      end
    end
  end

  // Present a request at posedge+1, hold it until accepted, return at posedge+1.
  task automatic enq(input logic [4:0] r, input logic [31:0] d);
    int waited = 0;
    bit done = 1'b0;
    inIf.InValid    = 1'b1;
    inIf.InRegister = r;
    inIf.InData     = d;
    while (!done && waited <= 50) begin
      @(negedge Clk);
      if (inIf.InReady === 1'b1) begin
        @(posedge Clk);
        done = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL enq_timeout: got no InReady for r%0d expected accept", r);
      @(posedge Clk);
    end
    #1;
    inIf.InValid    = 1'b0;
    inIf.InRegister = '0;
    inIf.InData     = '0;
    if (done && r != 5'd0) expQ.push_back('{r: r, d: d});
  endtask

  // Wait (bounded) for the queue to empty, then realign to posedge+1.
  task automatic wait_drain(input string name);
    bit empty = 1'b0;
    for (int i = 0; i < 60 && !empty; i++) begin
      @(negedge Clk);
      if (Count == 3'd0) empty = 1'b1;
    end
    if (!empty) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got Count %0d expected 0", name, Count);
    end
    check({name, "_q"}, 32'(expQ.size()), 32'd0);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n         = 1'b1;
    WriteHold       = 1'b0;
    ReadRegister1   = '0;
    ReadRegister2   = '0;
    inIf.InValid    = 1'b0;
    inIf.InRegister = '0;
    inIf.InData     = '0;

    // Reset state
    #2 Reset_n = 1'b0;
    #1;
    check("rst_count", 32'(Count), 32'd0);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_wreg", 32'(WriteRegister), 32'd0);
    check("rst_wdata", WriteData, 32'd0);
    check("rst_b1v", 32'(Bypass1Valid), 32'd0);
    check("rst_b2d", Bypass2Data, 32'd0);
    check("rst_inready", 32'(inIf.InReady), 32'd1);
    #9 Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Single write, one-cycle latency
    ReadRegister1 = 5'd5;
    enq(5'd5, 32'hDEADBEEF);
    check("single_regwrite", 32'(RegWrite), 32'd1);
    check("single_wreg", 32'(WriteRegister), 32'd5);
    check("single_wdata", WriteData, 32'hDEADBEEF);
    check("single_count", 32'(Count), 32'd1);
    check("single_b1v", 32'(Bypass1Valid), 32'd1);
    check("single_b1d", Bypass1Data, 32'hDEADBEEF);
    @(posedge Clk);
    #1;
    check("single_count_after", 32'(Count), 32'd0);
    check("single_regwrite_after", 32'(RegWrite), 32'd0);

    // Register 0 is accepted but dropped
    ReadRegister1 = 5'd0;
    enq(5'd0, 32'h12345678);
    check("r0_count", 32'(Count), 32'd0);
    check("r0_regwrite", 32'(RegWrite), 32'd0);
    check("r0_b1v", 32'(Bypass1Valid), 32'd0);

    // Fill under hold, stall a fifth request, then release
    WriteHold = 1'b1;
    for (int i = 1; i <= 4; i++) enq(5'(i), 32'(i));
    check("full_count", 32'(Count), 32'd4);
    check("full_inready", 32'(inIf.InReady), 32'd0);
    fork
      enq(5'd9, 32'h99);
      begin
        repeat (2) @(posedge Clk);
        #1;
        check("stall_count", 32'(Count), 32'd4);
        check("stall_inready", 32'(inIf.InReady), 32'd0);
        WriteHold = 1'b0;
        #1;
        check("full_pop_inready", 32'(inIf.InReady), 32'd0);
        check("full_pop_regwrite", 32'(RegWrite), 32'd1);
      end
    join
    wait_drain("fill");

    // Bypass picks the newest of two pending writes to the same register
    WriteHold = 1'b1;
    enq(5'd7, 32'h11);
    enq(5'd7, 32'h22);
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd0;
    #1;
    check("byp_b1v", 32'(Bypass1Valid), 32'd1);
    check("byp_b1d", Bypass1Data, 32'h22);
    check("byp_b2v", 32'(Bypass2Valid), 32'd0);
    check("byp_b2d", Bypass2Data, 32'd0);
    ReadRegister1 = 5'd8;
    ReadRegister2 = 5'd7;
    #1;
    check("byp_miss_b1v", 32'(Bypass1Valid), 32'd0);
    check("byp_miss_b1d", Bypass1Data, 32'd0);
    check("byp_b2v_hit", 32'(Bypass2Valid), 32'd1);
    check("byp_b2d_hit", Bypass2Data, 32'h22);
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    WriteHold = 1'b0;
    wait_drain("byp");

    // Enqueue and pop on the same edge
    WriteHold = 1'b1;
    enq(5'd10, 32'hA);
    enq(5'd11, 32'hB);
    check("simul_count_pre", 32'(Count), 32'd2);
    WriteHold = 1'b0;
    enq(5'd3, 32'h33);
    check("simul_count", 32'(Count), 32'd2);
    wait_drain("simul");

    // Stream ten writes through the wrapping pointers
    for (int i = 0; i < 10; i++) enq(5'(20 + i), 32'hC0DE_0000 + 32'(i));
    wait_drain("stream");
    check("stream_count", 32'(Count), 32'd0);

    // Reset mid-cycle with pending entries
    WriteHold = 1'b1;
    enq(5'd12, 32'hC);
    enq(5'd13, 32'hD);
    enq(5'd14, 32'hE);
    check("prerst_count", 32'(Count), 32'd3);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("midrst_regwrite", 32'(RegWrite), 32'd0);
    check("midrst_count", 32'(Count), 32'd0);
    check("midrst_wreg", 32'(WriteRegister), 32'd0);
    expQ.delete();
    #10 Reset_n = 1'b1;
    WriteHold = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    check("postrst_count", 32'(Count), 32'd0);
    check("postrst_regwrite", 32'(RegWrite), 32'd0);

    check("final_q", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
